qei_step_gen: RTL and testbench
===============================

QEI_STEP_GEN -- requirements
Module: qei_step_gen

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-002 The ports SHALL be exactly these (name, direction, width, meaning):
 - clk, in, 1: sole clock; all logic on rising edge.
 - rst, in, 1: synchronous active-high reset.
 - cmd_valid, in, 1: move request.
 - cmd_ready, out, 1: block can accept a move.
 - cmd_dir, in, 1: 1 = forward, 0 = backward.
 - cmd_steps, in, 16: quadrature edges to emit, unsigned; 0 = no-op.
 - cmd_period, in, 16: clk cycles per edge (dwell).
 - qa, out, 1: quadrature channel A, registered.
 - qb, out, 1: quadrature channel B, registered.
 - dir, out, 1: direction of the current or last move.
 - busy, out, 1: move in progress.
 - done, out, 1: one-cycle move-complete pulse.
 - position, out, 16: signed edge count, two's-complement wrap.

Function
REQ-003 Phase {qa,qb} SHALL step forward 00->01->11->10->00 and backward 00->10->11->01->00, and it SHALL change exactly one bit per edge.
REQ-004 States SHALL be IDLE, RUN and TAIL, and cmd_ready SHALL be 1 only in IDLE.
REQ-005 Acceptance SHALL occur when cmd_valid and cmd_ready are both high; on acceptance the block SHALL latch dir, steps and eff_period, where eff_period = max(cmd_period, 2).
REQ-006 On acceptance with steps = 0, the FSM SHALL stay in IDLE, done SHALL pulse on the next cycle, and the outputs SHALL be unchanged.
REQ-007 On acceptance with steps > 0, the FSM SHALL enter RUN; the first edge SHALL appear on qa/qb exactly eff_period cycles after the acceptance edge, and each later edge SHALL follow exactly eff_period cycles after the previous one.
REQ-008 On each edge, position SHALL change by +1 (forward) or -1 (backward) in the same cycle as the qa/qb change, and the remaining count SHALL decrement.
REQ-009 After the last edge, the FSM SHALL enter TAIL and hold qa/qb for eff_period cycles, then return to IDLE; done SHALL pulse in the cycle cmd_ready re-asserts.
REQ-010 busy SHALL be 1 in RUN and TAIL, and 0 in IDLE.
REQ-011 A command presented in the same cycle done pulses SHALL be accepted, so back-to-back moves are allowed.
REQ-012 cmd_* inputs SHALL be ignored while busy, and a direction change SHALL take effect only at a new command.
REQ-013 position SHALL wrap modulo 2^16 (0x7FFF + 1 = 0x8000, 0x0000 - 1 = 0xFFFF), and the phase SHALL persist across moves, never re-aligning to 00.
REQ-014 steps = 0xFFFF SHALL emit exactly 65535 edges.
REQ-015 No output SHALL be driven combinationally from any input.

Reset
REQ-016 While rst is high, the block SHALL hold: FSM = IDLE, qa = 0, qb = 0, dir = 1, position = 0, busy = 0, done = 0, cmd_ready = 0.
REQ-017 cmd_ready SHALL be 1 in the first cycle after rst falls.
REQ-018 Reset asserted mid-move SHALL abort the move, produce no done pulse, and return qa/qb to 00 on the next clock edge.

Structure
REQ-019 Package qei_pkg SHALL hold:
 - typedef phase_t (2-bit);
 - state enum (IDLE, RUN, TAIL);
 - constants POS_W = 16, STEP_W = 16, PERIOD_W = 16, MIN_PERIOD = 2;
 - forward and backward Gray sequence constants.
REQ-020 Sub-module qei_phase_seq SHALL be combinational and compute the next phase from phase and direction; the top SHALL hold the FSM, timer, remaining counter and position register.

Verification
REQ-021 Single forward step: steps = 1, period = 16, dir = 1 from reset -> qa/qb 00->01 at +16 cycles, position = 1, done pulses at +32 cycles.
REQ-022 Full cycles: forward, steps = 4, period = 16 -> phases 01, 11, 10, 00 at 16-cycle spacing and position = 4; then backward, steps = 4 -> phases 10, 11, 01, 00 and position = 0.
REQ-023 Bulk move: forward steps = 256 then backward steps = 256, period = 16 -> position delta +256 then -256, exactly one bit change per edge, and no edge spaced less than 16 cycles.
REQ-024 Edge cases:
 - period = 0 or 1 -> spacing of 2 cycles;
 - steps = 0 -> done pulse with no qa/qb activity;
 - a command held on the done cycle -> accepted with no idle gap.
REQ-025 Wrap: 32768 forward edges from reset -> position = 0x8000; then 1 backward edge -> position = 0x7FFF.
REQ-026 Reset mid-move: rst high after 3 of 10 edges -> qa/qb = 00, position = 0, busy = 0, no done pulse, cmd_ready = 1 on the cycle after rst falls.

Source files
------------

// File: rtl/qei_pkg.sv
// Shared types and constants for the quadrature step generator.
//   phase_t   : {qa,qb} phase word
//   state_t   : move FSM states
//   GRAY_FWD / GRAY_BWD : phase order for each direction, entry 0 = 2'b00
package qei_pkg;

    localparam int POS_W    = 16;
    localparam int STEP_W   = 16;
    localparam int PERIOD_W = 16;
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = 16'd2;

    typedef logic [1:0] phase_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } state_t;

    // Index i+1 (mod 4) is the phase that follows index i.
    localparam phase_t [3:0] GRAY_FWD = {2'b10, 2'b11, 2'b01, 2'b00};
    localparam phase_t [3:0] GRAY_BWD = {2'b01, 2'b11, 2'b10, 2'b00};

endpackage

// File: rtl/qei_phase_seq.sv
// Combinational next-phase lookup for the quadrature outputs.
//   phase     : current {qa,qb}
//   dir       : 1 = forward, 0 = backward
//   phase_nxt : {qa,qb} after one edge in the given direction
module qei_phase_seq
    import qei_pkg::*;
(
    input  phase_t phase,
    input  logic   dir,
    output phase_t phase_nxt
);

    always_comb begin
        phase_nxt = phase;
        for (int i = 0; i < 4; i++) begin
            if (dir && (GRAY_FWD[i] == phase)) phase_nxt = GRAY_FWD[2'(i + 1)];
            if (!dir && (GRAY_BWD[i] == phase)) phase_nxt = GRAY_BWD[2'(i + 1)];
        end
    end

endmodule

// File: rtl/qei_step_gen.sv
// Quadrature step generator: emits cmd_steps Gray-coded edges on qa/qb,
// one every max(cmd_period,2) clocks, then dwells one more period before
// reporting done. All outputs are registered.
//   clk, rst                    : clock, synchronous active-high reset
//   cmd_valid/cmd_ready         : move handshake (ready only when idle)
//   cmd_dir/cmd_steps/cmd_period: direction, edge count, cycles per edge
//   qa, qb                      : quadrature outputs
//   dir, busy, done             : last move direction, move active, done pulse
//   position                    : signed edge count, wraps modulo 2^16
module qei_step_gen
    import qei_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [STEP_W-1:0]   cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    output logic                qa,
    output logic                qb,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic [POS_W-1:0]    position
);

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   timer_q, timer_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [STEP_W-1:0]     remain_q, remain_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    phase_t                phase_q, phase_d, phase_nxt;
    logic                  dir_q, dir_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;

    logic                  accept;
    logic                  tick;
    logic [PERIOD_W-1:0]   eff_period;

    // ready_q is only ever set for IDLE, so it doubles as the state qualifier.
    assign accept     = cmd_valid && ready_q;
    assign tick       = (timer_q == '0);
    assign eff_period = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;

    qei_phase_seq u_phase_seq (
        .phase     (phase_q),
        .dir       (dir_q),
        .phase_nxt (phase_nxt)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (cmd_steps != '0)) state_d = RUN;
            RUN:     if (tick && (remain_q == STEP_W'(1))) state_d = TAIL;
            TAIL:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        timer_d  = timer_q;
        period_d = period_q;
        remain_d = remain_q;
        pos_d    = pos_q;
        phase_d  = phase_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_steps == '0) begin
                        // No-op move: acknowledge only, outputs untouched.
                        done_d = 1'b1;
                    end else begin
                        dir_d    = cmd_dir;
                        period_d = eff_period;
                        remain_d = cmd_steps;
                        // Counting down to zero makes the first edge land
                        // eff_period clocks after the acceptance edge.
                        timer_d  = eff_period - PERIOD_W'(1);
                    end
                end
            end
            RUN: begin
                if (tick) begin
                    phase_d  = phase_nxt;
                    pos_d    = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    remain_d = remain_q - STEP_W'(1);
                    timer_d  = period_q - PERIOD_W'(1);
                end else begin
                    timer_d = timer_q - PERIOD_W'(1);
                end
            end
            TAIL: begin
                if (tick) done_d = 1'b1;
                else      timer_d = timer_q - PERIOD_W'(1);
            end
            default: ;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            period_q <= '0;
            remain_q <= '0;
            pos_q    <= '0;
            phase_q  <= 2'b00;
            dir_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            remain_q <= remain_d;
            pos_q    <= pos_d;
            phase_q  <= phase_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign qa        = phase_q[1];
    assign qb        = phase_q[0];
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_qei_step_gen.sv
// Self-checking bench for qei_step_gen: table of moves with expected final
// state, a scoreboard of expected edge/done events checked by a monitor,
// plus hand-written reset and wrap sequences.
module tb_qei_step_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        qa, qb, dir, busy, done;
    logic [15:0] position;

    qei_step_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .qa         (qa),
        .qb         (qb),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference phase order, written independently of the RTL tables.
    function automatic logic [1:0] ref_next(input logic [1:0] ph, input logic d);
        logic [1:0] r;
        if (d) begin
            case (ph)
                2'b00: r = 2'b01;
                2'b01: r = 2'b11;
                2'b11: r = 2'b10;
                default: r = 2'b00;
            endcase
        end else begin
            case (ph)
                2'b00: r = 2'b10;
                2'b10: r = 2'b11;
                2'b11: r = 2'b01;
                default: r = 2'b00;
            endcase
        end
        return r;
    endfunction

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [1:0]  ph;
        logic [15:0] pos;
    } exp_t;

    exp_t sbq[$];
    bit          mon_en  = 1'b0;
    logic [1:0]  prev_ph = 2'b00;
    logic [1:0]  m_ph    = 2'b00;
    logic [15:0] m_pos   = '0;

    // Monitor: every qa/qb change and every done pulse must match the
    // next scoreboard entry exactly (cycle, phase, position).
    always @(negedge clk) begin
        logic [1:0] cur;
        exp_t       e;
        cur = {qa, qb};
        if (mon_en) begin
            if (cur !== prev_ph) begin
                check("one_bit_change", 32'($countones(cur ^ prev_ph)), 32'd1);
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_edge: got phase %b, expected no activity (cycle %0d)", cur, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("edge_kind", 32'(e.is_done), 32'd0);
                    check("edge_cycle", cyc, e.cyc);
                    check("edge_phase", 32'(cur), 32'(e.ph));
                    check("edge_position", 32'(position), 32'(e.pos));
                end
            end
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("done_kind", 32'(e.is_done), 32'd1);
                    check("done_cycle", cyc, e.cyc);
                    check("done_position", 32'(position), 32'(e.pos));
                    check("done_ready", 32'(cmd_ready), 32'd1);
                    check("done_busy", 32'(busy), 32'd0);
                end
            end
        end
        prev_ph = cur;
    end

    // Issue one move; push expected events; return in the done cycle so a
    // following call is accepted back-to-back.
    task automatic do_move(input bit d, input int steps, input int period,
                           input int gap, input bit noise);
        int eff, acc, done_cyc, bound, t;
        repeat (gap) begin @(negedge clk); #1; end
        eff = (period < 2) ? 2 : period;
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = steps[15:0];
        cmd_period = period[15:0];
        acc = cyc + 1;
        if (steps == 0) begin
            done_cyc = acc;
        end else begin
            for (int k = 1; k <= steps; k++) begin
                m_ph  = ref_next(m_ph, d);
                m_pos = d ? m_pos + 16'd1 : m_pos - 16'd1;
                sbq.push_back('{1'b0, acc + k * eff, m_ph, m_pos});
            end
            done_cyc = acc + (steps + 1) * eff;
        end
        sbq.push_back('{1'b1, done_cyc, m_ph, m_pos});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        bound = done_cyc - cyc + 20;
        for (t = 0; t < bound && sbq.size() != 0; t++) begin
            @(negedge clk); #1;
            // Garbage commands while busy must be ignored.
            if (noise && cyc < done_cyc) begin
                cmd_valid  = 1'($urandom_range(1));
                cmd_dir    = 1'($urandom_range(1));
                cmd_steps  = 16'($urandom_range(65535));
                cmd_period = 16'($urandom_range(65535));
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL move_timeout: got %0d pending events, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    typedef struct {
        bit          d;
        int          steps;
        int          period;
        int          gap;
        bit          noise;
        logic [15:0] exp_pos;
        logic [1:0]  exp_ph;
        bit          exp_dir;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #(2_000_000 * 10);
        $display("FAIL watchdog: got no finish, expected finish within bound");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit seen_done;
        vecs[0]  = '{1'b1,   1, 16, 2, 1'b0, 16'h0001, 2'b01, 1'b1};
        vecs[1]  = '{1'b0,   1, 16, 0, 1'b0, 16'h0000, 2'b00, 1'b0};
        vecs[2]  = '{1'b1,   4, 16, 0, 1'b0, 16'h0004, 2'b00, 1'b1};
        vecs[3]  = '{1'b0,   4, 16, 3, 1'b0, 16'h0000, 2'b00, 1'b0};
        vecs[4]  = '{1'b1, 256, 16, 0, 1'b0, 16'h0100, 2'b00, 1'b1};
        vecs[5]  = '{1'b0, 256, 16, 0, 1'b1, 16'h0000, 2'b00, 1'b0};
        vecs[6]  = '{1'b1,   3,  0, 1, 1'b0, 16'h0003, 2'b10, 1'b1};
        vecs[7]  = '{1'b0,   2,  1, 0, 1'b0, 16'h0001, 2'b01, 1'b0};
        vecs[8]  = '{1'b1,   0,  5, 0, 1'b0, 16'h0001, 2'b01, 1'b0};
        vecs[9]  = '{1'b0,   1,  3, 0, 1'b1, 16'h0000, 2'b00, 1'b0};
        vecs[10] = '{1'b0,   1,  2, 2, 1'b0, 16'hFFFF, 2'b10, 1'b0};
        vecs[11] = '{1'b1,   5,  7, 0, 1'b1, 16'h0004, 2'b00, 1'b1};

        // Reset values while rst is held
        repeat (3) @(posedge clk);
        #1;
        check("rst_qa", 32'(qa), 32'd0);
        check("rst_qb", 32'(qb), 32'd0);
        check("rst_dir", 32'(dir), 32'd1);
        check("rst_position", 32'(position), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(cmd_ready), 32'd1);
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            do_move(vecs[i].d, vecs[i].steps, vecs[i].period, vecs[i].gap, vecs[i].noise);
            check($sformatf("vec%0d_position", i), 32'(position), 32'(vecs[i].exp_pos));
            check($sformatf("vec%0d_phase", i), 32'({qa, qb}), 32'(vecs[i].exp_ph));
            check($sformatf("vec%0d_dir", i), 32'(dir), 32'(vecs[i].exp_dir));
        end

        // Reset in the middle of a 10-edge move, after the third edge
        @(negedge clk); #1;
        mon_en     = 1'b0;
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = 16'd10;
        cmd_period = 16'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (t = 0; t < 200 && position !== 16'h0007; t++) begin
            @(negedge clk); #1;
        end
        check("mid_move_three_edges", 32'(position), 32'h0007);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_qa_qb", 32'({qa, qb}), 32'd0);
        check("abort_position", 32'(position), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_after_rst", 32'(cmd_ready), 32'd1);
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        #1;
        check("abort_no_done", 32'(seen_done), 32'd0);
        m_ph  = 2'b00;
        m_pos = 16'h0000;
        mon_en = 1'b1;

        // Signed wrap at the half-range boundary
        do_move(1'b1, 32768, 2, 0, 1'b0);
        check("wrap_position_8000", 32'(position), 32'h8000);
        do_move(1'b0, 1, 2, 0, 1'b0);
        check("wrap_position_7fff", 32'(position), 32'h7FFF);
        check("wrap_phase", 32'({qa, qb}), 32'(2'b10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
